byte_memory_arbiter: RTL and testbench

- Sequences and shares the 4-entry x 8-bit byte memory system (latch-based byte stores, 2-bit address, level-sensitive store strobe) between two requesters.
- Requester 0 is the switch/button front panel. Requester 1 is an automatic sequencer (pattern/scan logic).
- Drives the memory's address, data and store lines with setup/strobe/hold sequencing, so no latch sees data or address change while store is high.
- Returns read data to the granted requester through a req/gnt/done handshake.

---
 rtl/byte_memory_arbiter_if.sv | 39 +++
 rtl/byte_memory_arbiter.sv | 157 +++++++++++++++
 tb/tb_byte_memory_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_memory_arbiter_if.sv
// Requester handshake and memory-bus bundle for byte_memory_arbiter.
// slave  : the arbiter side (takes requests, drives grants and the memory bus).
// master : the environment side (requesters plus the byte memory itself).
interface byte_memory_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_store;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
    output gnt0, done0, gnt1, done1, rdata, busy, mem_addr, mem_data, mem_store
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
    input  gnt0, done0, gnt1, done1, rdata, busy, mem_addr, mem_data, mem_store
  );
endinterface

// File: rtl/byte_memory_arbiter.sv
// Two-requester arbiter and store sequencer for a 2^ADDR_W x DATA_W latch-based
// byte memory. Address and data are set up one cycle before the store strobe and
// held HOLD_CYCLES (1..15) cycles after it, so no latch sees them move while open.
// Optional build macro BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN: round-robin tie-break;
// when undefined, requester 0 always wins a tie (fixed priority).
module byte_memory_arbiter #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int HOLD_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  byte_memory_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CAPTURE, DONE} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t            state, state_next;
  logic              gnt0, gnt0_next;
  logic              gnt1, gnt1_next;
  logic              done0, done0_next;
  logic              done1, done1_next;
  logic              store, store_next;
  logic              busy, busy_next;
  logic              we_q, we_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [DATA_W-1:0] data_q, data_next;
  logic [DATA_W-1:0] rdata_q, rdata_next;
  logic [3:0]        cnt, cnt_next;
  logic              pick1;
`ifdef BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN
  logic              last_served, last_served_next;
`endif

  // State register and registered outputs; reset aborts any access at once.
  // NOTE: every flop here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      store       <= 1'b0;
      busy        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      cnt         <= '0;
`ifdef BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN
      last_served <= 1'b1;
`endif
    end else begin
      state       <= state_next;
      gnt0        <= gnt0_next;
      gnt1        <= gnt1_next;
      done0       <= done0_next;
      done1       <= done1_next;
      store       <= store_next;
      busy        <= busy_next;
      we_q        <= we_next;
      addr_q      <= addr_next;
      data_q      <= data_next;
      rdata_q     <= rdata_next;
      cnt         <= cnt_next;
`ifdef BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN
      last_served <= last_served_next;
`endif
    end
  end

  // Next-state and next-output logic for the setup/strobe/hold/capture sequence.
  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    gnt0_next   = gnt0;
    gnt1_next   = gnt1;
    done0_next  = 1'b0;
    done1_next  = 1'b0;
    store_next  = 1'b0;
    we_next     = we_q;
    addr_next   = addr_q;
    data_next   = data_q;
    rdata_next  = rdata_q;
    cnt_next    = cnt;
    pick1       = 1'b0;
`ifdef BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN
    last_served_next = last_served;
    // On a tie, serve whoever was not served last.
    pick1 = bus.req1 && (!bus.req0 || !last_served);
`else
    // Fixed priority: requester 1 only wins when requester 0 is quiet.
    pick1 = bus.req1 && !bus.req0;
`endif

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_next = SETUP;
          gnt0_next  = !pick1;
          gnt1_next  = pick1;
          we_next    = pick1 ? bus.we1    : bus.we0;
          addr_next  = pick1 ? bus.addr1  : bus.addr0;
          data_next  = pick1 ? bus.wdata1 : bus.wdata0;
        end
      end
      SETUP: begin
        state_next = we_q ? STROBE : CAPTURE;
        store_next = we_q;
      end
      STROBE: begin
        state_next = HOLD;
        cnt_next   = HOLD_LOAD;
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_next = DONE;
          done0_next = gnt0;
          done1_next = gnt1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      CAPTURE: begin
        state_next = DONE;
        rdata_next = bus.mem_q;
        done0_next = gnt0;
        done1_next = gnt1;
      end
      DONE: begin
        state_next = IDLE;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
`ifdef BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN
        last_served_next = gnt1;
`endif
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.done0     = done0;
  assign bus.done1     = done1;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.mem_store = store;

endmodule

// File: tb/tb_byte_memory_arbiter.sv
// Self-checking bench for byte_memory_arbiter: one instance with HOLD_CYCLES=1 and
// one with HOLD_CYCLES=3, each with a behavioural byte memory. Expected results are
// queued when a request is issued and compared when the matching done pulse appears.
module tb_byte_memory_arbiter;

  typedef struct {
    int         who;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  logic       sel3 = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [7:0] shadow[2][4];

  byte_memory_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();
  byte_memory_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus3 ();

  byte_memory_arbiter #(.DATA_W(8), .ADDR_W(2), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  byte_memory_arbiter #(.DATA_W(8), .ADDR_W(2), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  assign bus.req0    = req0 & ~sel3;
  assign bus.req1    = req1 & ~sel3;
  assign bus3.req0   = req0 & sel3;
  assign bus3.req1   = req1 & sel3;
  assign bus.we0     = we0;    assign bus3.we0    = we0;
  assign bus.we1     = we1;    assign bus3.we1    = we1;
  assign bus.addr0   = addr0;  assign bus3.addr0  = addr0;
  assign bus.addr1   = addr1;  assign bus3.addr1  = addr1;
  assign bus.wdata0  = wdata0; assign bus3.wdata0 = wdata0;
  assign bus.wdata1  = wdata1; assign bus3.wdata1 = wdata1;

  // Behavioural byte memories: written while the strobe is high.
  logic [7:0] mem1[4];
  logic [7:0] mem3[4];
  always @(posedge clk) if (bus.mem_store)  mem1[bus.mem_addr]  <= bus.mem_data;
  always @(posedge clk) if (bus3.mem_store) mem3[bus3.mem_addr] <= bus3.mem_data;
  assign bus.mem_q  = mem1[bus.mem_addr];
  assign bus3.mem_q = mem3[bus3.mem_addr];

  // Observed outputs of whichever instance is selected.
  wire       o_gnt0  = sel3 ? bus3.gnt0  : bus.gnt0;
  wire       o_gnt1  = sel3 ? bus3.gnt1  : bus.gnt1;
  wire       o_done0 = sel3 ? bus3.done0 : bus.done0;
  wire       o_done1 = sel3 ? bus3.done1 : bus.done1;
  wire       o_store = sel3 ? bus3.mem_store : bus.mem_store;
  wire       o_busy  = sel3 ? bus3.busy  : bus.busy;
  wire [1:0] o_addr  = sel3 ? bus3.mem_addr : bus.mem_addr;
  wire [7:0] o_data  = sel3 ? bus3.mem_data : bus.mem_data;
  wire [7:0] o_rdata = sel3 ? bus3.rdata : bus.rdata;

  function automatic logic [7:0] mem_at(input logic [1:0] a);
    return sel3 ? mem3[a] : mem1[a];
  endfunction

  // Issue one request, follow it to done and score the result.
  task automatic do_req(input int who, input logic we, input logic [1:0] addr,
                        input logic [7:0] wd, input logic [7:0] wd_late,
                        output int lat, output logic gnt_first, output int store_cyc,
                        output logic setup_ok, output int post_cyc,
                        output logic other_gnt, output logic stable_ok);
    exp_t e, got;
    logic seen_store = 1'b0;
    logic done = 1'b0;
    logic [1:0] pa = '0;
    logic [7:0] pd = '0;
    lat = -1; gnt_first = 1'b0; store_cyc = 0; setup_ok = 1'b0;
    post_cyc = 0; other_gnt = 1'b0; stable_ok = 1'b1;
    e.who = who; e.we = we; e.addr = addr;
    e.data = we ? wd : shadow[sel3][addr];
    sb.push_back(e);
    if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else          begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        gnt_first = (who == 0) ? o_gnt0 : o_gnt1;
        if (who == 0) wdata0 = wd_late; else wdata1 = wd_late;
      end
      if ((who == 0) ? o_gnt1 : o_gnt0) other_gnt = 1'b1;
      done = (who == 0) ? o_done0 : o_done1;
      if (o_store) begin
        if (!seen_store) setup_ok = (pa == addr) && (pd == wd);
        store_cyc++;
        seen_store = 1'b1;
      end else if (seen_store && !done) begin
        post_cyc++;
      end
      if (seen_store && (o_addr !== addr || o_data !== wd)) stable_ok = 1'b0;
      pa = o_addr; pd = o_data;
      if (done) begin lat = c - 1; break; end
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    vectors++;
    if (lat < 0) begin
      miscompares++;
      $display("FAIL done_timeout: requester %0d got no done within 40 cycles", who);
      sb.delete();
      return;
    end
    got = sb.pop_front();
    if (got.we) begin
      if (mem_at(got.addr) !== got.data) begin
        miscompares++;
        $display("FAIL mem_write: mem[%0d]=%h want %h", got.addr, mem_at(got.addr), got.data);
      end
      shadow[sel3][got.addr] = got.data;
    end else if (o_rdata !== got.data) begin
      miscompares++;
      $display("FAIL read_data: rdata=%h want %h", o_rdata, got.data);
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({o_done0, o_done1, o_gnt0, o_gnt1} !== 4'b0000) begin
      miscompares++;
      $display("FAIL done_release: done0/1 gnt0/1=%b want 0000",
               {o_done0, o_done1, o_gnt0, o_gnt1});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_store, bus.busy,
         bus.mem_addr, bus.mem_data, bus.rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_state_h1: outputs=%h want 0", {bus.gnt0, bus.gnt1, bus.done0,
               bus.done1, bus.mem_store, bus.busy, bus.mem_addr, bus.mem_data, bus.rdata});
    end
    vectors++;
    if ({bus3.gnt0, bus3.gnt1, bus3.done0, bus3.done1, bus3.mem_store, bus3.busy,
         bus3.mem_addr, bus3.mem_data, bus3.rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_state_h3: outputs=%h want 0", {bus3.gnt0, bus3.gnt1, bus3.done0,
               bus3.done1, bus3.mem_store, bus3.busy, bus3.mem_addr, bus3.mem_data, bus3.rdata});
    end
    reset = 1'b0;
  endtask

  task automatic test_write();
    int lat, sc, pc; logic gf, so, og, st;
    sel3 = 1'b0;
    do_req(0, 1'b1, 2'd2, 8'hA5, 8'hA5, lat, gf, sc, so, pc, og, st);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wr_latency: got %0d want 3", lat); end
    vectors++; if (gf !== 1'b1) begin miscompares++; $display("FAIL wr_gnt0: got %b want 1", gf); end
    vectors++; if (sc !== 1) begin miscompares++; $display("FAIL wr_store_len: got %0d want 1", sc); end
    vectors++; if (so !== 1'b1) begin miscompares++; $display("FAIL wr_setup: got %b want 1", so); end
    vectors++; if (pc !== 1) begin miscompares++; $display("FAIL wr_hold: got %0d want 1", pc); end
    vectors++; if (og !== 1'b0) begin miscompares++; $display("FAIL wr_other_gnt: got %b want 0", og); end
  endtask

  task automatic test_read_back();
    int lat, sc, pc; logic gf, so, og, st;
    sel3 = 1'b0;
    do_req(1, 1'b0, 2'd2, 8'h00, 8'h00, lat, gf, sc, so, pc, og, st);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d want 2", lat); end
    vectors++; if (gf !== 1'b1) begin miscompares++; $display("FAIL rd_gnt1: got %b want 1", gf); end
    vectors++; if (og !== 1'b0) begin miscompares++; $display("FAIL rd_gnt0_seen: got %b want 0", og); end
    vectors++; if (sc !== 0) begin miscompares++; $display("FAIL rd_store: got %0d want 0", sc); end
  endtask

  task automatic test_wdata_change();
    int lat, sc, pc; logic gf, so, og, st;
    sel3 = 1'b0;
    do_req(0, 1'b1, 2'd3, 8'hA5, 8'h3C, lat, gf, sc, so, pc, og, st);
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL latch_stable: got %b want 1", st); end
    vectors++; if (o_rdata !== 8'hA5) begin miscompares++; $display("FAIL wr_keeps_rdata: got %h want a5", o_rdata); end
  endtask

  task automatic test_reset_mid_op();
    int lat, sc, pc; logic gf, so, og, st;
    logic hit = 1'b0;
    sel3 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h66;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (o_store) begin hit = 1'b1; break; end
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL rst_no_strobe: store never rose"); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({o_store, o_gnt0, o_busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_async: store/gnt0/busy=%b want 000", {o_store, o_gnt0, o_busy});
    end
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({o_done0, o_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_no_done: done0/busy=%b want 00", {o_done0, o_busy});
    end
    reset = 1'b0;
    @(negedge clk);
    do_req(0, 1'b1, 2'd1, 8'h77, 8'h77, lat, gf, sc, so, pc, og, st);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rst_reissue: latency %0d want 3", lat); end
  endtask

  task automatic test_tie();
    exp_t e, got;
    int served = 0;
    int who;
    sel3 = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN
      e.who = k % 2;
`else
      e.who = 0;
`endif
      e.we = 1'b1; e.addr = (e.who == 0) ? 2'd0 : 2'd1; e.data = (e.who == 0) ? 8'h11 : 8'h22;
      sb.push_back(e);
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h22;
    for (int c = 0; c < 80 && served < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (o_gnt0 && o_gnt1) begin
        vectors++; miscompares++;
        $display("FAIL tie_both_gnt: gnt0=1 gnt1=1 want one-hot");
      end
      if (o_done0 || o_done1) begin
        who = o_done1 ? 1 : 0;
        got = sb.pop_front();
        vectors++;
        if (who !== got.who) begin
          miscompares++;
          $display("FAIL tie_order[%0d]: served %0d want %0d", served, who, got.who);
        end
        vectors++;
        if (mem_at(got.addr) !== got.data) begin
          miscompares++;
          $display("FAIL tie_mem[%0d]: mem=%h want %h", served, mem_at(got.addr), got.data);
        end
        served++;
        if (served == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (served !== 4) begin
      miscompares++;
      $display("FAIL tie_timeout: served %0d want 4", served);
      sb.delete();
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL tie_idle: busy=%b want 0", o_busy); end
    shadow[0][0] = 8'h11;
`ifdef BYTE_MEMORY_ARBITER_ROUND_ROBIN_EN
    shadow[0][1] = 8'h22;
`endif
  endtask

  task automatic test_hold3();
    int lat, sc, pc; logic gf, so, og, st;
    sel3 = 1'b1;
    @(negedge clk);
    do_req(0, 1'b1, 2'd1, 8'h5A, 8'h5A, lat, gf, sc, so, pc, og, st);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL h3_latency: got %0d want 5", lat); end
    vectors++; if (pc !== 3) begin miscompares++; $display("FAIL h3_hold: got %0d want 3", pc); end
    vectors++; if (sc !== 1) begin miscompares++; $display("FAIL h3_store_len: got %0d want 1", sc); end
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL h3_stable: got %b want 1", st); end
    do_req(1, 1'b0, 2'd1, 8'h00, 8'h00, lat, gf, sc, so, pc, og, st);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL h3_rd_latency: got %0d want 2", lat); end
    do_req(1, 1'b1, 2'd1, 8'hC3, 8'hC3, lat, gf, sc, so, pc, og, st);
    vectors++; if (o_rdata !== 8'h5A) begin miscompares++; $display("FAIL h3_keeps_rdata: got %h want 5a", o_rdata); end
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL h3_wr1_latency: got %0d want 5", lat); end
    sel3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) shadow[i][j] = 8'h00;
    @(negedge clk);
    test_reset();
    test_write();
    test_read_back();
    test_wdata_change();
    test_reset_mid_op();
    test_tie();
    test_hold3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
